// File: rtl/gpio_event_ctrl.sv
// Edge-event controller: per-bit masked rise/fall detection into a FWFT FIFO drained over AXI4-Stream.
// Define GPIO_EVENT_TIMESTAMP_EN to append a free-running timestamp to each event word.
module gpio_event_ctrl #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned TS_WIDTH        = 32,
  parameter int unsigned FIFO_ADDR_WIDTH = 4,
`ifdef GPIO_EVENT_TIMESTAMP_EN
  localparam int unsigned EW = 2 * DATA_WIDTH + TS_WIDTH
`else
  localparam int unsigned EW = 2 * DATA_WIDTH
`endif
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [DATA_WIDTH-1:0]      din,
  input  logic [DATA_WIDTH-1:0]      cfg_rise_en,
  input  logic [DATA_WIDTH-1:0]      cfg_fall_en,
  input  logic                       clr_overflow,
  output logic [EW-1:0]              m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [FIFO_ADDR_WIDTH:0]   fifo_count,
  output logic                       overflow
);

  localparam int unsigned Depth = 1 << FIFO_ADDR_WIDTH;
  localparam logic [FIFO_ADDR_WIDTH:0] DepthCnt = (FIFO_ADDR_WIDTH + 1)'(Depth);
  localparam logic [FIFO_ADDR_WIDTH:0] PtrOne   = (FIFO_ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0]      din_q;
  logic                       armed_q;
  logic [FIFO_ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic                       overflow_q, overflow_d;
  logic [EW-1:0]              mem_q [Depth];

  logic [DATA_WIDTH-1:0]      rise, fall;
  logic [EW-1:0]              event_word;
  logic                       event_valid, full, empty, push, pop, drop;

  // Unarmed cycle masks detection so levels present at reset release never look like edges.
  always_comb begin
    rise        = din & ~din_q & cfg_rise_en;
    fall        = ~din & din_q & cfg_fall_en;
    event_valid = armed_q & (|(rise | fall));
  end

`ifdef GPIO_EVENT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_WIDTH'(1);
    end
  end

  assign event_word = {ts_q, fall, rise};
`else
  assign event_word = {fall, rise};
`endif

  always_comb begin
    fifo_count = wr_ptr_q - rd_ptr_q;
    full       = (fifo_count == DepthCnt);
    empty      = (fifo_count == '0);
    pop        = ~empty & m_axis_tready;
    // A full FIFO still accepts when the head leaves on the same edge.
    push       = event_valid & (~full | pop);
    drop       = event_valid & full & ~pop;
    wr_ptr_d   = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      din_q      <= '0;
      armed_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      din_q      <= din;
      armed_q    <= 1'b1;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q[FIFO_ADDR_WIDTH-1:0]] <= event_word;
    end
  end

  assign m_axis_tvalid = ~empty;
  assign m_axis_tdata  = empty ? '0 : mem_q[rd_ptr_q[FIFO_ADDR_WIDTH-1:0]];
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_gpio_event_ctrl.sv
// Directed bench for gpio_event_ctrl (default build): reset suppression, masking, backpressure,
// overflow, full-with-pop acceptance, clear race and mid-operation reset.
module tb_gpio_event_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] din, cfg_rise_en, cfg_fall_en;
  logic          clr_overflow;
  logic [2*DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready;
  logic [AW:0]   fifo_count;
  logic          overflow;

  int compared   = 0;
  int mismatched = 0;

  logic [2*DW-1:0] expq[$];
  logic [DW-1:0]   prev;
  logic [DW-1:0]   d;
  logic [2*DW-1:0] w;
  int              n;

  gpio_event_ctrl dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .din           (din),
    .cfg_rise_en   (cfg_rise_en),
    .cfg_fall_en   (cfg_fall_en),
    .clr_overflow  (clr_overflow),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .fifo_count    (fifo_count),
    .overflow      (overflow)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
  endtask

  // Event word with all masks enabled: {fall, rise}.
  function automatic logic [2*DW-1:0] ev(input logic [DW-1:0] cur, input logic [DW-1:0] old);
    return {~cur & old, cur & ~old};
  endfunction

  initial begin
    aresetn       = 1'b0;
    din           = 8'hFF;
    cfg_rise_en   = 8'hFF;
    cfg_fall_en   = 8'hFF;
    clr_overflow  = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) tick();
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);

    // Levels held through reset must not produce events.
    aresetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("lvl_tvalid", 64'(m_axis_tvalid), 64'd0);
    end

    // Single edge 00 -> 05.
    cfg_rise_en = 8'h00;
    cfg_fall_en = 8'h00;
    din = 8'h00;
    tick();
    cfg_rise_en   = 8'hFF;
    cfg_fall_en   = 8'hFF;
    m_axis_tready = 1'b1;
    din = 8'h05;
    #1;
    check("se_tvalid_pre", 64'(m_axis_tvalid), 64'd0);
    tick();
    check("se_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("se_tdata", 64'(m_axis_tdata), 64'h0005);
    check("se_count", 64'(fifo_count), 64'd1);
    tick();
    check("se_tvalid_post", 64'(m_axis_tvalid), 64'd0);
    check("se_count_post", 64'(fifo_count), 64'd0);

    // Masking: only rise on bit 0 counts.
    m_axis_tready = 1'b0;
    cfg_rise_en = 8'h01;
    cfg_fall_en = 8'h00;
    din = 8'h00;
    tick();
    din = 8'h03;
    tick();
    din = 8'h00;
    tick();
    tick();
    check("mask_count", 64'(fifo_count), 64'd1);
    check("mask_tdata", 64'(m_axis_tdata), 64'h0001);
    m_axis_tready = 1'b1;
    tick();
    check("mask_count_post", 64'(fifo_count), 64'd0);
    m_axis_tready = 1'b0;

    // Backpressure: 18 events into a 16-deep FIFO.
    cfg_rise_en = 8'hFF;
    cfg_fall_en = 8'hFF;
    prev = 8'h00;
    for (int k = 1; k <= 18; k++) begin
      d = 8'(k);
      w = ev(d, prev);
      if (k <= 16) expq.push_back(w);
      prev = d;
      din = d;
      tick();
      check("bp_tdata_stable", 64'(m_axis_tdata), 64'(expq[0]));
      if (k == 16) begin
        check("bp_count16", 64'(fifo_count), 64'd16);
        check("bp_ovf_before", 64'(overflow), 64'd0);
      end
    end
    check("bp_count", 64'(fifo_count), 64'd16);
    check("bp_overflow", 64'(overflow), 64'd1);

    // Full with simultaneous pop and event: accepted.
    d = 8'h40;
    w = ev(d, prev);
    check("fp_head", 64'(m_axis_tdata), 64'(expq[0]));
    void'(expq.pop_front());
    expq.push_back(w);
    prev = d;
    din = d;
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    check("fp_count", 64'(fifo_count), 64'd16);
    check("fp_overflow", 64'(overflow), 64'd1);
    check("fp_newhead", 64'(m_axis_tdata), 64'(expq[0]));

    // Clear racing a drop: set wins.
    d = 8'h00;
    prev = d;
    din = d;
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("race_overflow", 64'(overflow), 64'd1);
    check("race_count", 64'(fifo_count), 64'd16);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("clr_overflow", 64'(overflow), 64'd0);
    check("clr_head", 64'(m_axis_tdata), 64'(expq[0]));

    // Drain in order.
    m_axis_tready = 1'b1;
    n = expq.size();
    for (int i = 0; i < n; i++) begin
      check("drain_tvalid", 64'(m_axis_tvalid), 64'd1);
      check("drain_tdata", 64'(m_axis_tdata), 64'(expq[i]));
      tick();
    end
    check("drain_done_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("drain_done_count", 64'(fifo_count), 64'd0);
    m_axis_tready = 1'b0;

    // Reset mid-operation discards events and re-arms.
    din = 8'hFF;
    tick();
    din = 8'h0F;
    tick();
    check("mr_count_pre", 64'(fifo_count), 64'd2);
    aresetn = 1'b0;
    #1;
    check("mr_count_rst", 64'(fifo_count), 64'd0);
    check("mr_tvalid_rst", 64'(m_axis_tvalid), 64'd0);
    tick();
    aresetn = 1'b1;
    repeat (3) tick();
    check("mr_count_rearm", 64'(fifo_count), 64'd0);
    din = 8'h0E;
    tick();
    check("mr_count_ev", 64'(fifo_count), 64'd1);
    check("mr_tdata_ev", 64'(m_axis_tdata), 64'h0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gpio_event_ctrl.md
Name: gpio_event_ctrl

Overview:
- Event controller downstream of the GPIO debouncer.
- Watches the debounced GPIO word and detects per-bit rising and falling edges, each gated by runtime enable masks.
- Queues one event word per edge-bearing cycle in an internal FIFO and presents it on an AXI4-Stream master for the PS/DMA side.
- Tracks lost events with a sticky overflow flag.

Parameters:
- DATA_WIDTH, 8, width of the debounced GPIO word.
- TS_WIDTH, 32, width of the free-running timestamp counter (used only with the optional feature).
- FIFO_ADDR_WIDTH, 4, log2 of FIFO depth (default depth 16).

Ports:
- aclk  input  1  system clock.
- aresetn  input  1  asynchronous, active-low reset.
- din  input  DATA_WIDTH  debounced GPIO word, synchronous to aclk.
- cfg_rise_en  input  DATA_WIDTH  per-bit rising-edge enable.
- cfg_fall_en  input  DATA_WIDTH  per-bit falling-edge enable.
- clr_overflow  input  1  single-cycle pulse; clears the overflow flag.
- m_axis_tdata  output  EW  event word; EW = 2*DATA_WIDTH, or 2*DATA_WIDTH+TS_WIDTH with the optional feature.
- m_axis_tvalid  output  1  FIFO not empty.
- m_axis_tready  input  1  downstream accept.
- fifo_count  output  FIFO_ADDR_WIDTH+1  current occupancy, 0..2^FIFO_ADDR_WIDTH.
- overflow  output  1  sticky; an event was dropped.

Behaviour:
Reset (aresetn low, asynchronous):
- FIFO empty; m_axis_tvalid=0, fifo_count=0, overflow=0, m_axis_tdata=0.
- din_q=0, armed=0, timestamp=0.

Arming:
- First aclk edge after reset release: din_q<=din, armed<=1.
- No event is generated on that edge, so input levels present at reset never produce spurious edges.

Edge detection (combinational, evaluated each cycle with armed=1):
- rise = din & ~din_q & cfg_rise_en.
- fall = ~din & din_q & cfg_fall_en.
- din_q<=din on every edge.
- An event exists when |(rise|fall).
- Mask inputs are used as sampled in the detection cycle; no shadowing.
- A bit toggling while its enable is 0 is lost; it is not retried later.

Event word:
- Bits [DATA_WIDTH-1:0] = rise; bits [2*DATA_WIDTH-1:DATA_WIDTH] = fall.
- Several bits changing in one cycle produce exactly one word.

Latency:
- din changes after edge k-1 → word written at edge k → m_axis_tvalid=1 after edge k when the FIFO was empty.
- The FIFO is first-word-fall-through: the head word is valid on m_axis_tdata whenever tvalid=1.

Handshake:
- A pop occurs on an edge with tvalid & tready.
- tdata is held stable while tvalid=1 and tready=0.
- tvalid never drops without a pop or a reset.

FIFO:
- Depth 2^FIFO_ADDR_WIDTH; pointers are FIFO_ADDR_WIDTH+1 bits and wrap naturally.
- Full when count = depth.
- Push only; count +1. Pop only; count -1. Push and pop on the same edge: count unchanged.
- Full with simultaneous pop and event: the event is accepted, because the slot frees on the same edge.
- Full with event and no pop: the event is dropped, FIFO contents unchanged, overflow<=1.
- Empty with tready=1: nothing happens; tready is ignored.

Overflow:
- Set by a drop; cleared by clr_overflow.
- Drop and clr_overflow on the same edge: overflow stays 1 (set wins).

Reset mid-operation:
- All queued events are discarded and armed returns to 0.

Optional Feature:
- Macro GPIO_EVENT_TIMESTAMP_EN.
- Defined:
  - A TS_WIDTH counter increments every aclk edge from 0 after reset and wraps to 0 after all-ones.
  - Each event word carries the counter value at the edge where it is written, in bits [EW-1:2*DATA_WIDTH].
  - Dropped events are not timestamped.
- Undefined:
  - No counter is built; EW = 2*DATA_WIDTH.
  - All other behaviour is identical.

Test Plan:
1. Reset-level suppression: hold din=8'hFF through reset and release with both masks 8'hFF → no event, tvalid stays 0 for 20 cycles.
2. Single edge: masks 8'hFF, tready=1, din 8'h00→8'h05 → one word, rise=8'h05 and fall=8'h00, tvalid high exactly one cycle after the change; with the timestamp feature, TS equals the cycle count since release.
3. Masking: cfg_rise_en=8'h01, cfg_fall_en=8'h00, din 8'h00→8'h03→8'h00 → exactly one word, rise=8'h01 and fall=8'h00.
4. Backpressure and overflow (depth 16): tready=0, generate 18 events → fifo_count=16, overflow=1, tdata stable. Then tready=1 → the 16 words come out in order and tvalid drops.
5. Full plus simultaneous pop/push: FIFO full, tready=1 on the same cycle as an event → event accepted, fifo_count stays 16, overflow unchanged.
6. Clear race: assert clr_overflow on the same cycle as a drop → overflow remains 1. Assert clr_overflow alone → overflow becomes 0 on the next edge.
